// File: rtl/fp24_pkg.sv
// Shared field layout, packed view and value classes for the 24-bit float format.
package fp24_pkg;

  localparam int SIGN_BIT = 23;
  localparam int EXP_MSB  = 22;
  localparam int EXP_LSB  = 15;
  localparam int MANT_W   = 15;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  typedef struct packed {
    logic                     sign;
    logic [EXP_MSB-EXP_LSB:0] exp;
    logic [MANT_W-1:0]        mant;
  } fp24_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  // Denormals share the zero class: they are flushed before conversion.
  function automatic fp_class_e fp24_classify(input fp24_t f);
    fp_class_e c;
    if (f.exp == '0)
      c = FP_ZERO;
    else if (int'(f.exp) == EXP_MAX)
      c = (f.mant == '0) ? FP_INF : FP_NAN;
    else
      c = FP_NORM;
    return c;
  endfunction

endpackage

// File: rtl/fp24_shift_round.sv
// Second-stage datapath: aligns the 16-bit significand by a signed shift, rounds,
// and flags results that cannot be represented for the given sign.
module fp24_shift_round #(
  parameter int OUT_WIDTH     = 32,
  parameter int ROUND_NEAREST = 1
) (
  input  logic                 [15:0]          m,
  input  logic signed          [9:0]           sh,
  input  logic                                 sign,
  output logic                 [OUT_WIDTH-1:0] mag,
  output logic                                 overflow
);

  localparam int MW     = OUT_WIDTH + 1;
  // Largest left shift whose result still fits exactly in MW bits; beyond it
  // the leading one lands at or above bit OUT_WIDTH, which always overflows.
  localparam int SH_FIT = OUT_WIDTH - 16;
  localparam logic [MW-1:0] LIM_NEG = MW'(1) << (OUT_WIDTH - 1);
  localparam logic [MW-1:0] LIM_POS = LIM_NEG - MW'(1);

  int          sh_i;
  int          rshift;
  logic        big;
  logic [MW-1:0] wide;
  logic [31:0] frac_ext;
  logic        guard;
  logic        sticky;
  logic        round_up;

  always_comb begin
    sh_i     = int'(sh);
    rshift   = 0;
    big      = 1'b0;
    wide     = '0;
    frac_ext = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    round_up = 1'b0;
    if (sh_i >= 0) begin
      if (sh_i > SH_FIT)
        big = 1'b1;
      else
        wide = MW'(m) << sh_i;
    end else begin
      rshift = -sh_i;
      // Shifts of 17 or more leave nothing, not even a guard bit.
      if (rshift <= 16) begin
        frac_ext = {m, 16'b0} >> rshift;
        guard    = frac_ext[15];
        sticky   = |frac_ext[14:0];
        round_up = (ROUND_NEAREST != 0) && guard && (sticky || frac_ext[16]);
        wide     = MW'(frac_ext[31:16]) + MW'(round_up);
      end
    end
    overflow = big || (wide > (sign ? LIM_NEG : LIM_POS));
  end

  assign mag = wide[OUT_WIDTH-1:0];

endmodule

// File: rtl/fp24_to_fixed.sv
// Two-stage fp24 to signed Q-format converter with valid/ready on both sides.
// A beat transfers on a side when valid && ready are both high at the clock edge.
module fp24_to_fixed
  import fp24_pkg::*;
#(
  parameter int OUT_WIDTH     = 32,
  parameter int FRAC_BITS     = 8,
  parameter int ROUND_NEAREST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [23:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic                 out_invalid
);

  localparam logic [OUT_WIDTH-1:0] POS_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] NEG_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  fp24_t             in_f;
  int                sh_calc;
  logic              s2_en;
  logic              s1_advance;
  logic              in_fire;

  logic              s1_valid;
  logic              s1_sign;
  fp_class_e         s1_class;
  logic signed [9:0] s1_sh;
  logic [15:0]       s1_m;

  logic [OUT_WIDTH-1:0] mag;
  logic                 ovf;
  logic [OUT_WIDTH-1:0] res_data;
  logic                 res_sat;
  logic                 res_inv;

  assign in_f       = in_data;
  assign s2_en      = !out_valid || out_ready;
  assign s1_advance = s1_valid && s2_en;
  assign in_ready   = !s1_valid || s1_advance;
  assign in_fire    = in_valid && in_ready;

  // Shift that places the significand's binary point FRAC_BITS above bit 0.
  always_comb sh_calc = int'(in_f.exp) - (EXP_BIAS + MANT_W) + FRAC_BITS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_class <= FP_ZERO;
      s1_sh    <= '0;
      s1_m     <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_sign  <= in_f.sign;
        s1_class <= fp24_classify(in_f);
        s1_sh    <= 10'(sh_calc);
        s1_m     <= {1'b1, in_f.mant};
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  fp24_shift_round #(
    .OUT_WIDTH    (OUT_WIDTH),
    .ROUND_NEAREST(ROUND_NEAREST)
  ) u_shift_round (
    .m       (s1_m),
    .sh      (s1_sh),
    .sign    (s1_sign),
    .mag     (mag),
    .overflow(ovf)
  );

  always_comb begin
    res_data = '0;
    res_sat  = 1'b0;
    res_inv  = 1'b0;
    case (s1_class)
      FP_NAN: res_inv = 1'b1;
      FP_INF: begin
        res_sat  = 1'b1;
        res_data = s1_sign ? NEG_MIN : POS_MAX;
      end
      FP_NORM: begin
        if (ovf) begin
          res_sat  = 1'b1;
          res_data = s1_sign ? NEG_MIN : POS_MAX;
        end else begin
          res_data = s1_sign ? (~mag + 1'b1) : mag;
        end
      end
      default: ;
    endcase
  end

  // Output register only reloads when it is empty or being drained, so a
  // stalled result stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sat     <= 1'b0;
      out_invalid <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data    <= res_data;
        out_sat     <= res_sat;
        out_invalid <= res_inv;
      end
    end
  end

endmodule
